// File: rtl/dmem_arb_pkg.sv
// Shared sizes, read-tag layout and small helpers for the data-memory arbiter.
// Words are 24 bits; addresses and per-port data buses are HBIT_ADDR+1 bits wide.
package dmem_arb_pkg;
  localparam int WORD_W     = 24;
  localparam int HBIT_ADDR  = 47;
  localparam int ACC_W      = 2 * WORD_W;
  localparam int DMEM_PORTS = 2;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is48;
    logic   port;
  } rd_tag_t;

  function automatic rd_tag_t mk_tag(logic rd, owner_e owner, logic is48, logic port);
    rd_tag_t t;
    t.valid = rd;
    t.owner = owner;
    t.is48  = is48;
    t.port  = port;
    return t;
  endfunction

  function automatic logic [HBIT_ADDR:0] zext_word(logic [WORD_W-1:0] w);
    return {{(HBIT_ADDR + 1 - WORD_W){1'b0}}, w};
  endfunction
endpackage

// File: rtl/dmem_arb_tag.sv
// Per-port read-tag pipeline: remembers who owns each port's read for one cycle
// and steers the synchronous memory data back to that requester.
module dmem_arb_tag
  import dmem_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  rd_tag_t            tag_d_i     [0:DMEM_PORTS-1],
  input  logic [HBIT_ADDR:0] mem_rdata_i [0:DMEM_PORTS-1],
  output logic               a_rvalid_o,
  output logic [ACC_W-1:0]   a_rdata_o,
  output logic               b_rvalid_o,
  output logic [ACC_W-1:0]   b_rdata_o
);
  rd_tag_t            tag_q [0:DMEM_PORTS-1];
  logic [ACC_W-1:0]   steer_data;
  logic               unused_rdata_hi;

  assign unused_rdata_hi = ^{mem_rdata_i[0][HBIT_ADDR:WORD_W], mem_rdata_i[1][HBIT_ADDR:WORD_W]};

  // Clearing the tags on reset drops any read still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < DMEM_PORTS; p++) tag_q[p] <= '0;
    end else begin
      for (int p = 0; p < DMEM_PORTS; p++) tag_q[p] <= tag_d_i[p];
    end
  end

  always_comb begin
    a_rvalid_o = 1'b0;
    a_rdata_o  = '0;
    b_rvalid_o = 1'b0;
    b_rdata_o  = '0;
    steer_data = '0;
    for (int p = 0; p < DMEM_PORTS; p++) begin
      if (tag_q[p].valid) begin
        steer_data = tag_q[p].is48 ? {mem_rdata_i[1][WORD_W-1:0], mem_rdata_i[0][WORD_W-1:0]}
                                   : {{WORD_W{1'b0}}, mem_rdata_i[tag_q[p].port][WORD_W-1:0]};
        if (tag_q[p].owner == OWN_A) begin
          a_rvalid_o = 1'b1;
          a_rdata_o  = steer_data;
        end else begin
          b_rvalid_o = 1'b1;
          b_rdata_o  = steer_data;
        end
      end
    end
  end
endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter/sequencer for the dual-port 24-bit-word data memory.
// Grant logic, B starvation counter and port mapping live here; read return is in dmem_arb_tag.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter bit PAIR_24    = 1'b1
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_a_req,
  input  logic               iw_a_we,
  input  logic               iw_a_is48,
  input  logic [HBIT_ADDR:0] iw_a_addr,
  input  logic [ACC_W-1:0]   iw_a_wdata,
  output logic               ow_a_gnt,
  output logic               ow_a_rvalid,
  output logic [ACC_W-1:0]   ow_a_rdata,
  input  logic               iw_b_req,
  input  logic               iw_b_we,
  input  logic               iw_b_is48,
  input  logic [HBIT_ADDR:0] iw_b_addr,
  input  logic [ACC_W-1:0]   iw_b_wdata,
  output logic               ow_b_gnt,
  output logic               ow_b_rvalid,
  output logic [ACC_W-1:0]   ow_b_rdata,
  output logic               ow_mem_we    [0:DMEM_PORTS-1],
  output logic [HBIT_ADDR:0] ow_mem_addr  [0:DMEM_PORTS-1],
  output logic [HBIT_ADDR:0] ow_mem_wdata [0:DMEM_PORTS-1],
  output logic               ow_mem_is48  [0:DMEM_PORTS-1],
  input  logic [HBIT_ADDR:0] iw_mem_rdata [0:DMEM_PORTS-1]
);
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                a_gnt, b_gnt, pair_ok, b_first;
  logic                sel_b, s_we, s_is48;
  owner_e              s_owner;
  logic [HBIT_ADDR:0]  s_addr;
  logic [ACC_W-1:0]    s_wdata;
  rd_tag_t             tag_d [0:DMEM_PORTS-1];

  // Same-word pairs with a write are serialized so a read never sees a half-done update.
  always_comb begin
    pair_ok = PAIR_24 && !iw_a_is48 && !iw_b_is48 &&
              !((iw_a_addr == iw_b_addr) && (iw_a_we || iw_b_we));
    b_first = (starve_q == STARVE_W'(STARVE_MAX));
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    if (!iw_rst) begin
      if (iw_a_req && iw_b_req) begin
        if (pair_ok) begin
          a_gnt = 1'b1;
          b_gnt = 1'b1;
        end else if (b_first) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = iw_a_req;
        b_gnt = iw_b_req;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (iw_b_req && !b_gnt) starve_d = b_first ? starve_q : starve_q + STARVE_W'(1);
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  always_comb begin
    for (int p = 0; p < DMEM_PORTS; p++) begin
      ow_mem_we[p]    = 1'b0;
      ow_mem_addr[p]  = '0;
      ow_mem_wdata[p] = '0;
      ow_mem_is48[p]  = 1'b0;
      tag_d[p]        = '0;
    end
    sel_b   = b_gnt && !a_gnt;
    s_we    = sel_b ? iw_b_we    : iw_a_we;
    s_is48  = sel_b ? iw_b_is48  : iw_a_is48;
    s_addr  = sel_b ? iw_b_addr  : iw_a_addr;
    s_wdata = sel_b ? iw_b_wdata : iw_a_wdata;
    s_owner = sel_b ? OWN_B : OWN_A;
    if (a_gnt && b_gnt) begin
      ow_mem_we[0]    = iw_a_we;
      ow_mem_addr[0]  = iw_a_addr;
      ow_mem_wdata[0] = zext_word(iw_a_wdata[WORD_W-1:0]);
      tag_d[0]        = mk_tag(!iw_a_we, OWN_A, 1'b0, 1'b0);
      ow_mem_we[1]    = iw_b_we;
      ow_mem_addr[1]  = iw_b_addr;
      ow_mem_wdata[1] = zext_word(iw_b_wdata[WORD_W-1:0]);
      tag_d[1]        = mk_tag(!iw_b_we, OWN_B, 1'b0, 1'b1);
    end else if (a_gnt || b_gnt) begin
      ow_mem_we[0]    = s_we;
      ow_mem_addr[0]  = s_addr;
      ow_mem_wdata[0] = zext_word(s_wdata[WORD_W-1:0]);
      ow_mem_is48[0]  = s_is48;
      tag_d[0]        = mk_tag(!s_we, s_owner, s_is48, 1'b0);
      // The upper word of a 48-bit access wraps to address 0 at the top of memory.
      if (s_is48) begin
        ow_mem_we[1]    = s_we;
        ow_mem_addr[1]  = s_addr + (HBIT_ADDR + 1)'(1);
        ow_mem_wdata[1] = zext_word(s_wdata[ACC_W-1:WORD_W]);
        ow_mem_is48[1]  = 1'b1;
        tag_d[1]        = mk_tag(!s_we, s_owner, 1'b1, 1'b1);
      end
    end
  end

  assign ow_a_gnt = a_gnt;
  assign ow_b_gnt = b_gnt;

  dmem_arb_tag u_tag (
    .clk_i       (iw_clk),
    .rst_i       (iw_rst),
    .tag_d_i     (tag_d),
    .mem_rdata_i (iw_mem_rdata),
    .a_rvalid_o  (ow_a_rvalid),
    .a_rdata_o   (ow_a_rdata),
    .b_rvalid_o  (ow_b_rvalid),
    .b_rdata_o   (ow_b_rdata)
  );
endmodule
